if_id_fetch: RTL and testbench
==============================

// Module: if_id_fetch
// PURPOSE
//  Fetch stage between the program counter and decode. Issues the PC to a synchronous instruction memory.
//  Captures the returned instruction with its PC in a 2-entry skid FIFO, which forms the IF/ID pipeline register.
//  Produces pc_en so the PC advances only when a fetch is issued or a branch redirect occurs.
//  Absorbs decode stalls and drops wrong-path fetches on branch flush.
// PARAMETERS
//  XLEN       32            data/address width
//  NOP_INSTR  32'h00000013  instruction presented on id_instr when id_valid=0 (addi x0,x0,0)
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high
//  pc_in        in   XLEN  current PC from program counter
//  flush        in   1     br_taken from execute; redirect, kill all fetched/in-flight work
//  stall        in   1     decode cannot accept id_* this cycle
//  pc_en        out  1     PC update enable (advance by 4 or load branch target)
//  imem_req     out  1     fetch request; imem_addr valid this cycle
//  imem_addr    out  XLEN  fetch address (= pc_in)
//  imem_rdata   in   XLEN  instruction, valid exactly 1 cycle after imem_req; memory never refuses
//  id_valid     out  1     id_* hold a valid instruction
//  id_pc        out  XLEN  PC of id_instr
//  id_pc_plus4  out  XLEN  id_pc + 4, modulo 2^XLEN
//  id_instr     out  XLEN  instruction to decode
// BEHAVIOUR
//  - Reset (async) values:
//    - FIFO count=0 and pending=0.
//    - id_valid=0, id_pc=0, id_pc_plus4=4, id_instr=NOP_INSTR.
//    - imem_req=0 and pc_en=0 while reset is high.
//  - pop = id_valid & ~stall & ~flush.
//    - Pops the FIFO head at the clock edge.
//  - Issue:
//    - imem_req = ~flush & (count + pending - pop < 2).
//    - imem_addr = pc_in.
//    - pending <= imem_req, and the request PC is latched alongside it.
//  - Response:
//    - In the cycle after the request (pending=1), {req_pc, imem_rdata} is pushed to the FIFO tail.
//    - The push is skipped if flush=1 in that cycle.
//  - pc_en = imem_req | flush.
//    - Increment vs branch-target load is selected by the PC itself.
//  - The issue rule guarantees push never hits a full FIFO.
//    - Overflow is a design error; flag it with an assertion.
//  - id_* = FIFO head, driven from registers with no combinational path from imem_rdata.
//    - id_instr=NOP_INSTR and id_valid=0 when count=0.
//  - Latency: PC issued at cycle t appears on id_* at t+2.
//    - Steady-state throughput is 1 instruction per cycle (count=1, pending=1, pop=1 -> issue).
//  - Stall: id_* hold their values. Issue stops once count+pending reaches 2. No loss, no duplication.
//  - Flush: on the edge, FIFO cleared and pending cleared (in-flight response discarded).
//    - No request that cycle, because pc_in is stale.
//    - Next cycle: id_valid=0, fetch issues at the new pc_in.
//  - Flush and stall in the same cycle: flush wins.
//  - Reset mid-operation: all state cleared immediately. The first request issues the cycle after reset deasserts.
//  - Address wrap: id_pc_plus4 wraps modulo 2^XLEN. No other special handling.
// STRUCTURE
//  - cpu_pkg holds:
//    - XLEN and NOP_INSTR.
//    - typedef struct packed {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;} fetch_entry_t.
//  - Sub-module fetch_fifo: 2-entry FIFO of fetch_entry_t.
//    - Ports: push, pop, clear, count[1:0], head.
//    - Registered storage, 1-bit rd/wr pointers.
//  - Top level holds the pending/req_pc register, the issue/credit logic, and the output muxing.
// TESTING
//  1. Reset, release, PC model counts from 0, imem returns {addr}^32'hA5A5_0000:
//     id_pc 0,4,8,... on consecutive cycles from the 2nd cycle after release; id_instr matches; id_pc_plus4=id_pc+4.
//  2. stall=1 for 3 cycles while id_pc=8:
//     id_* hold 8; imem_req=0 once count+pending=2; after release id_pc 8,12,16 with no gap or repeat.
//  3. flush=1 (target 0x100) while the fetch of 0x10 is pending:
//     0x10 never appears; id_valid=0 next cycle; the next valid id_pc is 0x100, 2 cycles after the first request at 0x100.
//  4. flush=1 and stall=1 in the same cycle with FIFO full:
//     FIFO empties, id_valid=0 next cycle, fetch resumes at target.
//  5. reset asserted asynchronously mid-stream, away from the clock edge:
//     id_valid, imem_req, pc_en go 0 immediately; after release the sequence restarts at 0.
//  6. pc_in=32'hFFFF_FFFC:
//     id_pc=32'hFFFF_FFFC, id_pc_plus4=0; the following fetch at 0 delivers normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Fetch entries pair each instruction with the PC it was fetched from.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry skid FIFO of fetch entries.
// Acts as the IF/ID pipeline register; the head is read straight from storage.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage write; entries reset to zero so the idle head shows PC 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; clear drops every entry at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head is a pure register read, no path from the memory data input.
    always_comb begin
        head = mem[rd_ptr];
    end

    // The issue credit rule must never let a push land on a full FIFO.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (reset)
        (push && !clear) |-> (count != 2'd2 || pop)
    );

    // Popping an empty FIFO would mean id_valid was wrong.
    a_no_underflow : assert property (
        @(posedge clk) disable iff (reset)
        (pop && !clear) |-> (count != 2'd0)
    );

endmodule

// File: rtl/if_id_fetch.sv
// Fetch stage: issues PCs to a synchronous imem and buffers responses.
// Credit logic keeps at most two instructions buffered or in flight.
module if_id_fetch
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    input  logic            stall,
    output logic            pc_en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [XLEN-1:0] id_instr
);

    logic            pending;
    logic [XLEN-1:0] req_pc;
    logic [1:0]      count;
    logic            pop;
    logic            push;
    logic [2:0]      credit;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    // Handshake and issue credit: occupancy after this edge must stay below 2.
    always_comb begin
        pop        = id_valid & ~stall & ~flush;
        credit     = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
        imem_req   = ~reset & ~flush & (credit < 3'd2);
        pc_en      = imem_req | (flush & ~reset);
        imem_addr  = pc_in;
        push       = pending & ~flush;
        push_entry = '{pc: req_pc, instr: imem_rdata};
    end

    // In-flight request tracking; a flush leaves nothing pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            req_pc  <= '0;
        end else begin
            pending <= imem_req;
            if (imem_req) begin
                req_pc <= pc_in;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (push_entry),
        .count (count),
        .head  (head)
    );

    // Decode-side outputs; an empty FIFO presents a NOP.
    always_comb begin
        id_valid    = (count != 2'd0);
        id_pc       = head.pc;
        id_pc_plus4 = head.pc + 32'd4;
        id_instr    = id_valid ? head.instr : NOP_INSTR;
    end

endmodule

// File: tb/tb_if_id_fetch.sv
// Testbench for if_id_fetch with PC/imem models and a queue scoreboard.
// Directed scenarios are followed by a randomized stall/flush phase.
module tb_if_id_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        flush;
    logic        stall;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;

    logic [31:0] target;
    logic [31:0] pc_q;

    int tests;
    int fails;
    int n_pop;

    logic [31:0] exp_q[$];
    logic [31:0] inflight[$];
    logic [31:0] watch_pc;
    bit          watch_hit;

    if_id_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .flush       (flush),
        .stall       (stall),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter: step by 4 or load the branch target when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= 32'd0;
        else if (pc_en) pc_q <= flush ? target : pc_q + 32'd4;
    end
    assign pc_in = pc_q;

    // Synchronous imem; garbage on idle cycles exposes stray captures.
    always_ff @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ KEY;
        else imem_rdata <= $urandom;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampling 1 time unit before each rising edge.
    always begin
        int  occ;
        bit  consume;
        bit  exp_req;
        @(negedge clk);
        #4;
        if (id_valid && id_pc == watch_pc) watch_hit = 1'b1;
        if (reset) begin
            exp_q.delete();
            inflight.delete();
        end else begin
            consume = (exp_q.size() != 0) && !stall && !flush;
            chk("id_valid", {31'd0, id_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("id_pc", id_pc, exp_q[0]);
                chk("id_instr", id_instr, exp_q[0] ^ KEY);
                chk("id_pc_plus4", id_pc_plus4, exp_q[0] + 32'd4);
            end else begin
                chk("id_instr_nop", id_instr, NOP);
            end
            occ = exp_q.size() + inflight.size() - (consume ? 1 : 0);
            exp_req = !flush && (occ < 2);
            chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            chk("pc_en", {31'd0, pc_en}, {31'd0, exp_req || flush});
            if (exp_req) chk("imem_addr", imem_addr, pc_in);
            if (consume) begin
                n_pop++;
                void'(exp_q.pop_front());
            end
            if (flush) begin
                exp_q.delete();
                inflight.delete();
            end else begin
                foreach (inflight[i]) exp_q.push_back(inflight[i]);
                inflight.delete();
                if (exp_req) inflight.push_back(pc_in);
            end
        end
    end

    task automatic step(bit st, bit fl, logic [31:0] tg);
        @(negedge clk);
        stall  = st;
        flush  = fl;
        target = tg;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid_pc(logic [31:0] a, string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (id_valid && id_pc == a) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 32'd0);
        end
        chk(nm, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        tests     = 0;
        fails     = 0;
        n_pop     = 0;
        reset     = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        target    = 32'd0;
        watch_pc  = 32'hFFFF_FFFF;
        watch_hit = 1'b0;

        // Reset values
        #12;
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_pc4", id_pc_plus4, 32'd4);
        chk("rst_instr", id_instr, NOP);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);

        // 1: streaming from 0
        apply_reset();
        n0 = n_pop;
        repeat (12) step(1'b0, 1'b0, 32'd0);
        chk("t1_throughput", n_pop - n0, 32'd10);

        // 2: stall with id_pc = 8
        apply_reset();
        wait_valid_pc(32'd8, "t2_reach8");
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t2_hold", id_pc, 32'd8);
        end
        chk("t2_req_off", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        @(negedge clk);
        chk("t2_next12", id_pc, 32'd12);
        @(negedge clk);
        chk("t2_next16", id_pc, 32'd16);

        // 3: flush while 0x10 is in flight
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #3;
            if (imem_req && imem_addr == 32'h10) break;
        end
        chk("t3_saw_req10", imem_addr, 32'h10);
        watch_pc  = 32'h10;
        watch_hit = 1'b0;
        step(1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 32'd0);
        chk("t3_empty", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        chk("t3_empty2", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        chk("t3_valid", {31'd0, id_valid}, 32'd1);
        chk("t3_pc100", id_pc, 32'h100);
        repeat (6) step(1'b0, 1'b0, 32'd0);
        chk("t3_no_0x10", {31'd0, watch_hit}, 32'd0);
        watch_pc = 32'hFFFF_FFFF;

        // 4: flush plus stall with a full FIFO
        apply_reset();
        wait_valid_pc(32'd8, "t4_reach8");
        stall = 1'b1;
        repeat (3) @(negedge clk);
        flush  = 1'b1;
        target = 32'h200;
        step(1'b0, 1'b0, 32'd0);
        chk("t4_empty", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        chk("t4_empty2", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        chk("t4_pc200", id_pc, 32'h200);
        chk("t4_valid", {31'd0, id_valid}, 32'd1);

        // 5: asynchronous reset mid-stream
        repeat (5) step(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_valid", {31'd0, id_valid}, 32'd0);
        chk("t5_req", {31'd0, imem_req}, 32'd0);
        chk("t5_pc_en", {31'd0, pc_en}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_wait", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        chk("t5_restart", id_pc, 32'd0);
        chk("t5_restart_v", {31'd0, id_valid}, 32'd1);

        // 6: address wrap
        apply_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0);
        wait_valid_pc(32'hFFFF_FFFC, "t6_reach");
        chk("t6_pc4_wrap", id_pc_plus4, 32'd0);
        @(negedge clk);
        chk("t6_next0", id_pc, 32'd0);
        chk("t6_instr0", id_instr, KEY);

        // Random stall/flush traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        end
        repeat (4) step(1'b0, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
